// File: rtl/traffic_light.sv
// Two-street traffic light controller: a six-state Moore FSM sequenced purely by
// per-state dwell counts, with both streets held red during reset and any illegal state.
module traffic_light #(
    parameter int unsigned GREEN_CYCLES  = 8,
    parameter int unsigned YELLOW_CYCLES = 3,
    parameter int unsigned ALLRED_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] street_a,
    output logic [2:0] street_b
);

    typedef enum logic [2:0] {
        AR_A  = 3'd0,
        A_GRN = 3'd1,
        A_YEL = 3'd2,
        AR_B  = 3'd3,
        B_GRN = 3'd4,
        B_YEL = 3'd5
    } state_e;

    localparam logic [7:0] GREEN_LAST  = 8'(GREEN_CYCLES - 1);
    localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_CYCLES - 1);
    localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_CYCLES - 1);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] last_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= AR_A;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Last counter value of the current state; the state ends on the edge that sees it.
    always_comb begin
        last_cnt = ALLRED_LAST;
        case (state_q)
            A_GRN, B_GRN: last_cnt = GREEN_LAST;
            A_YEL, B_YEL: last_cnt = YELLOW_LAST;
            default:      last_cnt = ALLRED_LAST;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        case (state_q)
            AR_A:  if (cnt_q >= last_cnt) begin state_d = A_GRN; cnt_d = 8'd0; end
            A_GRN: if (cnt_q >= last_cnt) begin state_d = A_YEL; cnt_d = 8'd0; end
            A_YEL: if (cnt_q >= last_cnt) begin state_d = AR_B;  cnt_d = 8'd0; end
            AR_B:  if (cnt_q >= last_cnt) begin state_d = B_GRN; cnt_d = 8'd0; end
            B_GRN: if (cnt_q >= last_cnt) begin state_d = B_YEL; cnt_d = 8'd0; end
            B_YEL: if (cnt_q >= last_cnt) begin state_d = AR_A;  cnt_d = 8'd0; end
            default: begin
                state_d = AR_A;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Lamps depend on the state register alone, so illegal encodings fall back to all-red.
    always_comb begin
        street_a = LAMP_RED;
        street_b = LAMP_RED;
        case (state_q)
            A_GRN:   street_a = LAMP_GREEN;
            A_YEL:   street_a = LAMP_YELLOW;
            B_GRN:   street_b = LAMP_GREEN;
            B_YEL:   street_b = LAMP_YELLOW;
            default: begin
                street_a = LAMP_RED;
                street_b = LAMP_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light.sv
// Bench for traffic_light: a default-timed and a 1/1/1-timed instance share clock and reset
// and are compared every cycle against a phase model driven by edges since reset release.
module tb_traffic_light;

    logic       clk;
    logic       rst_n;
    logic [2:0] a_def, b_def;
    logic [2:0] a_fast, b_fast;

    int passed = 0;
    int total  = 0;
    int k_edges;

    traffic_light dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .street_a (a_def),
        .street_b (b_def)
    );

    traffic_light #(
        .GREEN_CYCLES  (1),
        .YELLOW_CYCLES (1),
        .ALLRED_CYCLES (1)
    ) dut_fast (
        .clk      (clk),
        .rst_n    (rst_n),
        .street_a (a_fast),
        .street_b (b_fast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges seen since reset was last released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k_edges <= 0;
        else        k_edges <= k_edges + 1;
    end

    // Expected {street_a, street_b} after k edges: position in the period picks the phase.
    function automatic logic [5:0] model(input int k, input int g, input int y, input int r);
        int p;
        p = k % (2 * (g + y + r));
        if (p < r)                   return {3'b100, 3'b100};
        if (p < r + g)               return {3'b001, 3'b100};
        if (p < r + g + y)           return {3'b010, 3'b100};
        if (p < 2 * r + g + y)       return {3'b100, 3'b100};
        if (p < 2 * r + 2 * g + y)   return {3'b100, 3'b001};
        return {3'b100, 3'b010};
    endfunction

    task automatic check_one(input string tag, input logic [2:0] a, input logic [2:0] b,
                             input logic [5:0] exp);
        total++;
        assert ({a, b} === exp) passed++;
        else $error("FAIL %s t=%0t k=%0d observed a=%b b=%b expected a=%b b=%b",
                    tag, $time, k_edges, a, b, exp[5:3], exp[2:0]);
        total++;
        assert ($onehot(a) && $onehot(b) && (a == 3'b100 || b == 3'b100)) passed++;
        else $error("FAIL %s_safety t=%0t observed a=%b b=%b expected one-hot with a red street",
                    tag, $time, a, b);
    endtask

    task automatic check_cycle(input string tag);
        check_one({tag, "_def"},  a_def,  b_def,  model(k_edges, 8, 3, 1));
        check_one({tag, "_fast"}, a_fast, b_fast, model(k_edges, 1, 1, 1));
        $display("[%0t] %s k=%0d def a=%b b=%b fast a=%b b=%b",
                 $time, tag, k_edges, a_def, b_def, a_fast, b_fast);
    endtask

    initial begin
        int wait_cnt;
        rst_n = 1'b0;

        // Reset held: all red before any edge and after an edge inside reset.
        #1;
        check_one("rst_pre_edge_def",  a_def,  b_def,  {3'b100, 3'b100});
        check_one("rst_pre_edge_fast", a_fast, b_fast, {3'b100, 3'b100});
        #6;
        check_one("rst_held_def",  a_def,  b_def,  {3'b100, 3'b100});
        check_one("rst_held_fast", a_fast, b_fast, {3'b100, 3'b100});
        #3;
        rst_n = 1'b1;

        // Directed walk through one full period and into the next A green.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check_cycle("seq");
        end

        // Land in B green, then pull reset between edges.
        wait_cnt = 0;
        while ((k_edges % 24) != 16 && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        total++;
        assert (wait_cnt < 100) passed++;
        else $error("FAIL reach_bgrn observed wait=%0d expected < 100", wait_cnt);
        total++;
        assert ({a_def, b_def} === {3'b100, 3'b001}) passed++;
        else $error("FAIL in_bgrn observed a=%b b=%b expected a=100 b=001", a_def, b_def);
        #2;
        rst_n = 1'b0;
        #1;
        check_one("async_rst_def",  a_def,  b_def,  {3'b100, 3'b100});
        check_one("async_rst_fast", a_fast, b_fast, {3'b100, 3'b100});
        @(negedge clk);
        check_cycle("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_one("after_rel_def", a_def, b_def, {3'b001, 3'b100});
        check_cycle("after_rel");

        // Long randomized run with occasional asynchronous resets at random phase.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            check_cycle("run");
            if ($urandom_range(0, 99) < 2) begin
                #($urandom_range(1, 3));
                rst_n = 1'b0;
                #1;
                check_cycle("rnd_rst");
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    check_cycle("rnd_hold");
                end
                rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/traffic_light.md
TRAFFIC_LIGHT -- requirements
Module: traffic_light

Interface
REQ-001 Parameter GREEN_CYCLES, default 8: green duration per street, in clock cycles; legal range 1..255.
REQ-002 Parameter YELLOW_CYCLES, default 3: yellow duration per street, in clock cycles; legal range 1..255.
REQ-003 Parameter ALLRED_CYCLES, default 1: all-red guard duration, in clock cycles; legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes SHALL occur on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 street_a  output  3  lamp for street A, encoded {red, yellow, green}: bit2=red, bit1=yellow, bit0=green.
REQ-007 street_b  output  3  lamp for street B, same encoding as street_a.

Function
REQ-008 Moore FSM with six states SHALL run in this cyclic order: AR_A, A_GRN, A_YEL, AR_B, B_GRN, B_YEL, then back to AR_A.
REQ-009 Outputs per state SHALL be (street_a/street_b):
- AR_A = 100/100
- A_GRN = 001/100
- A_YEL = 010/100
- AR_B = 100/100
- B_GRN = 100/001
- B_YEL = 100/010
REQ-010 Outputs SHALL be decoded only from the state register, with no combinational path from rst_n deassertion timing or counter value.
REQ-011 An 8-bit dwell counter SHALL count 0..N-1 in each state, where N is the state's parameter (GREEN_CYCLES, YELLOW_CYCLES or ALLRED_CYCLES).
REQ-012 On the edge where the counter equals N-1, the FSM SHALL advance to the next state and clear the counter to 0, so each state lasts exactly N cycles.
REQ-013 N=1 SHALL produce a one-cycle state, with a transition on every edge.
REQ-014 Full cycle period SHALL be 2*(GREEN_CYCLES+YELLOW_CYCLES+ALLRED_CYCLES) cycles (24 with defaults).
REQ-015 Safety: at no time SHALL both streets be non-red.
REQ-016 Each output SHALL always be exactly one-hot (never 000, never multiple bits set).
REQ-017 Any unreachable or illegal state encoding SHALL transition to AR_A with the counter cleared on the next edge.
REQ-017a While in an illegal state, both outputs SHALL be 100.
REQ-018 There are no other inputs; sequencing SHALL be purely time-based.

Reset
REQ-019 While rst_n=0, the state SHALL be AR_A, the counter SHALL be 0, and street_a=street_b=100, applied immediately without waiting for a clock edge.
REQ-020 After rst_n rises, the first rising clk edge SHALL be counted as cycle 1 of AR_A.
REQ-021 Reset asserted mid-operation (in any state or counter value) SHALL abort immediately to AR_A/100/100.
REQ-022 After reset releases again, the sequence SHALL restart from REQ-020 with no residual counter state.

Verification
REQ-023 Bench setup: clk period 10 ns starting at 0; rst_n=0 until 10 ns, then 1 (defaults G=8, Y=3, R=1).
REQ-024 Scenario: reset held -> street_a=street_b=100 before any clock edge and throughout reset.
REQ-025 Scenario: first edge after release (15 ns) -> A_GRN, a=001 b=100, held 8 edges.
- Then A_YEL, a=010, for 3 edges.
- Then AR_B, 100/100, for 1 edge.
- Then B_GRN, b=001, for 8 edges.
- Then B_YEL, b=010, for 3 edges.
- Then AR_A for 1 edge.
- Then a=001 again, 24 edges after the first A_GRN.
REQ-026 Scenario: run 1000 cycles -> every cycle satisfies REQ-015 and REQ-016; each state occurrence lasts exactly its parameter length.
REQ-027 Scenario: assert rst_n=0 asynchronously mid-B_GRN (between edges) -> outputs become 100/100 within the same cycle.
- Release rst_n -> A_GRN on the first edge.
REQ-028 Scenario: override G=1, Y=1, R=1 -> period 6 cycles, state changes on every edge, safety invariants hold.
